psc_trigger_tx: RTL

Multi-channel, single-clock successor to the PSC trigger transmit path. It synchronises NUM_CH asynchronous EVR trigger inputs and queues one pending request per channel. It serialises one 4-byte trigger frame per request onto the PSC fibre/LVDS line: sync byte, channel id, sequence number and CRC-8. Each byte goes out as a 10-bit start/data/stop symbol at clk/BIT_DIV. Bit timing uses clock enables, not derived clocks, so the block sits directly on the 50 MHz system clock and drives the PSC output pin.

---
 rtl/psc_trigger_pkg.sv | 23 ++
 rtl/psc_trigger_edge_sync.sv | 29 ++
 rtl/psc_trigger_tx.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/psc_trigger_pkg.sv
// Shared types, frame constants and CRC helper for the PSC trigger transmitter.
package psc_trigger_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  localparam int unsigned SYMBOL_BITS = 10;
  localparam int unsigned FRAME_BYTES = 4;

  // CRC-8, polynomial 0x07, MSB-first, no reflection, no final XOR.
  function automatic logic [7:0] crc8_07(input logic [7:0] crc_in, input logic [7:0] data_byte);
    logic [7:0] c;
    c = crc_in ^ data_byte;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/psc_trigger_edge_sync.sv
// One trigger channel: 2-flop synchroniser, edge-detect register and a
// registered rising-edge pulse.
module psc_trigger_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic trig_async,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  // Synchronise the asynchronous trigger and emit a one-cycle pulse per rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      meta <= trig_async;
      sync <= meta;
      prev <= sync;
      rise <= sync & ~prev;
    end
  end

endmodule

// File: rtl/psc_trigger_tx.sv
// Multi-channel PSC trigger transmitter: queues one request per channel and
// serialises 4-byte frames (sync, channel, seq, CRC-8) as 10-bit symbols.
module psc_trigger_tx
  import psc_trigger_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned BIT_DIV   = 5,
  parameter logic [7:0]  SYNC_BYTE = 8'hBC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] trig_in,
  input  logic              enable,
  input  logic              clear_overflow,
  output logic              psc_output,
  output logic              busy,
  output logic [NUM_CH-1:0] overflow
);

  localparam int unsigned      DIV_W     = $clog2(BIT_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BIT_DIV - 1);
  localparam logic [3:0]       BIT_LAST  = 4'(SYMBOL_BITS - 1);
  localparam logic [1:0]       BYTE_LAST = 2'(FRAME_BYTES - 1);

  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] sel_mask;
  logic [NUM_CH-1:0] clr_mask;
  logic [7:0]        sel_ch;

  state_t            state, state_n;
  logic [DIV_W-1:0]  div_cnt, div_n;
  logic [3:0]        bit_idx, bit_n;
  logic [1:0]        byte_idx, byte_n;
  logic              out_n, busy_n, load;

  logic [7:0] seq;
  logic [7:0] frame_ch;
  logic [7:0] frame_seq;
  logic [7:0] frame_crc;
  logic [7:0] cur_byte;

  // Line level for symbol bit idx of data: start 0, data LSB-first, stop 1.
  function automatic logic sym_bit(input logic [7:0] data, input logic [3:0] idx);
    logic [3:0] k;
    k = idx - 4'd1;
    if (idx == 4'd0) return 1'b0;
    if (idx == BIT_LAST) return 1'b1;
    return data[k[2:0]];
  endfunction

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    psc_trigger_edge_sync u_sync (
      .clk        (clk),
      .reset      (reset),
      .trig_async (trig_in[g]),
      .rise       (rise[g])
    );
  end

  // Fixed priority: lowest pending channel index wins.
  always_comb begin
    sel_ch   = '0;
    sel_mask = '0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (pending[i-1]) begin
        sel_ch   = 8'(i - 1);
        sel_mask = NUM_CH'(1) << (i - 1);
      end
    end
  end

  // Byte currently on the line.
  always_comb begin
    case (byte_idx)
      2'd0:    cur_byte = SYNC_BYTE;
      2'd1:    cur_byte = frame_ch;
      2'd2:    cur_byte = frame_seq;
      default: cur_byte = frame_crc;
    endcase
  end

  // Next-state and next registered outputs; psc_output is precomputed so the pin is a flop.
  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    out_n   = psc_output;
    busy_n  = busy;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (enable && (|pending)) begin
          load    = 1'b1;
          state_n = SEND;
          div_n   = '0;
          bit_n   = '0;
          byte_n  = '0;
          out_n   = 1'b0;
          busy_n  = 1'b1;
        end
      end
      SEND: begin
        if (div_cnt == DIV_LAST) begin
          div_n = '0;
          if (bit_idx == BIT_LAST) begin
            bit_n = '0;
            if (byte_idx == BYTE_LAST) begin
              state_n = GAP;
              out_n   = 1'b1;
            end else begin
              byte_n = byte_idx + 2'd1;
              out_n  = 1'b0;
            end
          end else begin
            bit_n = bit_idx + 4'd1;
            out_n = sym_bit(cur_byte, bit_idx + 4'd1);
          end
        end else begin
          div_n = div_cnt + DIV_W'(1);
        end
      end
      GAP: begin
        out_n = 1'b1;
        if (div_cnt == DIV_LAST) begin
          div_n   = '0;
          state_n = IDLE;
          busy_n  = 1'b0;
        end else begin
          div_n = div_cnt + DIV_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        out_n   = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  // FSM, bit timing and registered line outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      psc_output <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      div_cnt    <= div_n;
      bit_idx    <= bit_n;
      byte_idx   <= byte_n;
      psc_output <= out_n;
      busy       <= busy_n;
    end
  end

  assign clr_mask = load ? sel_mask : '0;

  // Request queue, overflow flags and frame load; a new edge beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending   <= '0;
      overflow  <= '0;
      seq       <= '0;
      frame_ch  <= '0;
      frame_seq <= '0;
      frame_crc <= '0;
    end else begin
      pending  <= (pending & ~clr_mask) | rise;
      overflow <= (clear_overflow ? '0 : overflow) | (rise & pending & ~clr_mask);
      if (load) begin
        frame_ch  <= sel_ch;
        frame_seq <= seq;
        frame_crc <= crc8_07(crc8_07(8'h00, sel_ch), seq);
        seq       <= seq + 8'd1;
      end
    end
  end

endmodule
